// File: rtl/fir_mac_sched.sv
// Round-robin scheduler for a shared serial FIR MAC: per-channel delay lines,
// shared coefficient bank, one tap per cycle, tagged result strobe.
module fir_mac_sched #(
  parameter  int NCH  = 2,
  parameter  int NTAP = 3,
  parameter  int DW   = 8,
  parameter  int CW   = 8,
  parameter  int AW   = 18,
  localparam int TAW  = (NTAP > 1) ? $clog2(NTAP) : 1,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*DW-1:0]    in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 coef_we,
  input  logic [TAW-1:0]       coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_ready,
  output logic signed [DW-1:0] mac_a,
  output logic signed [CW-1:0] mac_b,
  output logic                 mac_en,
  output logic                 mac_clr,
  input  logic signed [AW-1:0] mac_acc,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_chan,
  output logic signed [AW-1:0] out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t               r_state, w_state_nxt;
  logic signed [DW-1:0] r_x [NCH][NTAP];
  logic signed [CW-1:0] r_h [NTAP];
  logic [CHW-1:0]       r_rr, r_ch;
  logic [TAW-1:0]       r_tap;

  logic [CHW-1:0]       w_gnt_idx, w_cand;
  logic                 w_gnt_any, w_coef_wr, w_hs;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_cand = CHW'((int'(r_rr) + i) % NCH);
      if (!w_gnt_any && in_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_coef_wr = (r_state == S_IDLE) && coef_we;
  assign w_hs      = (r_state == S_IDLE) && !coef_we && w_gnt_any && !rst;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = '0;
    coef_ready  = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    out_valid   = 1'b0;
    out_chan    = '0;
    out_data    = '0;
    case (r_state)
      S_IDLE: begin
        coef_ready = 1'b1;
        if (w_hs) begin
          in_ready[w_gnt_idx] = 1'b1;
          w_state_nxt         = S_RUN;
        end
      end
      S_RUN: begin
        mac_a   = r_x[r_ch][r_tap];
        mac_b   = r_h[r_tap];
        mac_en  = 1'b1;
        mac_clr = (r_tap == '0);
        if (r_tap == TAW'(NTAP - 1)) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid   = 1'b1;
        out_chan    = r_ch;
        out_data    = mac_acc;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= CHW'(NCH - 1);
      r_ch    <= '0;
      r_tap   <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAP; k++)
          r_x[c][k] <= '0;
      for (int k = 0; k < NTAP; k++)
        r_h[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_coef_wr && (int'(coef_addr) < NTAP))
        r_h[coef_addr] <= coef_data;
      if (w_hs) begin
        r_ch           <= w_gnt_idx;
        r_rr           <= w_gnt_idx;
        r_tap          <= '0;
        r_x[w_gnt_idx][0] <= in_data[w_gnt_idx*DW +: DW];
        for (int k = 1; k < NTAP; k++)
          r_x[w_gnt_idx][k] <= r_x[w_gnt_idx][k-1];
      end else if (r_state == S_RUN) begin
        r_tap <= r_tap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched with a behavioural external MAC register.
module tb_fir_mac_sched;
  localparam int NCH = 2, NTAP = 3, DW = 8, CW = 8, AW = 18;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*DW-1:0]    in_data = '0;
  logic [NCH-1:0]       in_ready;
  logic                 coef_we = 1'b0;
  logic [1:0]           coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 coef_ready;
  logic signed [DW-1:0] mac_a;
  logic signed [CW-1:0] mac_b;
  logic                 mac_en, mac_clr;
  logic signed [AW-1:0] mac_acc = '0;
  logic                 out_valid;
  logic [0:0]           out_chan;
  logic signed [AW-1:0] out_data;
  logic                 busy;
  logic signed [AW-1:0] w_prod;

  int n_tests = 0, n_fail = 0, cyc = 0, last_hs = -100;

  fir_mac_sched #(.NCH(NCH), .NTAP(NTAP), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External MAC: accumulator updates on the edge that samples mac_en.
  assign w_prod = mac_a * mac_b;
  always @(posedge clk) if (mac_en) mac_acc <= mac_clr ? w_prod : mac_acc + w_prod;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic signed [CW-1:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d; #1;
    chk("coef_ready_idle", coef_ready, 1);
    step();
    coef_we = 1'b0;
  endtask

  task automatic wait_grant(input int c, input string tag);
    int t = 0;
    while (!in_ready[c] && t < 20) begin step(); t++; end
    chk({tag, "_grant"}, in_ready[c], 1);
  endtask

  task automatic wait_out(input int hs, input int c, input longint exp, input string tag);
    int t = 0;
    while (!out_valid && t < 20) begin step(); t++; end
    chk({tag, "_lat"}, cyc - hs, NTAP + 1);
    chk({tag, "_chan"}, out_chan, c);
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic send(input int c, input logic signed [DW-1:0] d, input longint exp,
                      input string tag, input bit spacing);
    int hs;
    in_data[c*DW +: DW] = d; in_valid[c] = 1'b1; #1;
    wait_grant(c, tag);
    hs = cyc;
    if (spacing) chk({tag, "_spacing"}, (hs - last_hs) >= NTAP + 2, 1);
    last_hs = hs;
    step();
    in_valid[c] = 1'b0;
    wait_out(hs, c, exp, tag);
  endtask

  logic [NCH-1:0]       exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  longint               exp_res [4] = '{5, -10, 5, 30};
  logic signed [DW-1:0] nxt_dat [4] = '{8'sd2, 8'sd4, 8'sd0, 8'sd0};

  initial begin
    int hs, t;
    bit saw_out;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_handshake_outs", {in_ready, out_valid, mac_en, mac_clr, busy}, 0);
    chk("rst_operands", {mac_a, mac_b, out_chan, out_data}, 0);
    chk("rst_coef_ready", coef_ready, 1);

    write_coef(2'd0, 8'sd5);
    write_coef(2'd1, -8'sd5);
    write_coef(2'd2, 8'sd15);
    send(0, 8'sd1, 5, "probe", 1'b0);
    send(0, 8'sd2, 5, "seq2", 1'b1);
    send(0, 8'sd3, 20, "seq3", 1'b1);

    // coefficient write attempted during RUN must be ignored
    in_data[7:0] = 8'sd4; in_valid[0] = 1'b1; #1;
    wait_grant(0, "busyw");
    hs = cyc;
    step();
    in_valid[0] = 1'b0;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd7; #1;
    chk("run_tap0_flags", {busy, mac_en, mac_clr}, 3'b111);
    chk("run_coef_ready", coef_ready, 0);
    chk("run_in_ready", in_ready, 0);
    step(); step();
    chk("run_tap2_clr", mac_clr, 0);
    step();
    coef_we = 1'b0;
    wait_out(hs, 0, 35, "busyw");
    send(0, 8'sd5, 50, "after_busyw", 1'b1);

    // write in IDLE beats a pending request
    step();
    in_data[7:0] = 8'sd6; in_valid[0] = 1'b1;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd7; #1;
    chk("idlew_no_grant", in_ready, 0);
    chk("idlew_coef_ready", coef_ready, 1);
    step();
    coef_we = 1'b0;
    send(0, 8'sd6, 77, "idlew", 1'b0);

    step();
    write_coef(2'd3, 8'sd99);
    send(0, 8'sd7, 94, "drop_addr3", 1'b0);

    // reset during tap 1 discards the result and clears state
    step();
    in_data[7:0] = 8'sd8; in_valid[0] = 1'b1; #1;
    wait_grant(0, "midrst");
    step();
    in_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_mac_en", mac_en, 0);
    saw_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) saw_out = 1'b1;
      step();
    end
    chk("midrst_no_out", saw_out, 0);
    send(0, 8'sd9, 0, "midrst_zero", 1'b0);

    // fresh reset so rr points at channel 0 first
    step();
    rst = 1'b1; step(); rst = 1'b0;
    write_coef(2'd0, 8'sd5);
    write_coef(2'd1, -8'sd5);
    write_coef(2'd2, 8'sd15);
    in_data[7:0] = 8'sd1; in_data[15:8] = -8'sd2; in_valid = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (in_ready == 0 && t < 20) begin step(); t++; end
      chk("rr_grant", in_ready, exp_gnt[i]);
      hs = cyc;
      step();
      if (exp_gnt[i][0]) in_data[7:0] = nxt_dat[i];
      else               in_data[15:8] = nxt_dat[i];
      wait_out(hs, exp_gnt[i][0] ? 0 : 1, exp_res[i], "rr");
      step();
    end
    in_valid = '0;

    write_coef(2'd0, -8'sd128);
    write_coef(2'd1, -8'sd128);
    write_coef(2'd2, -8'sd128);
    send(0, -8'sd128, 16000, "ext1", 1'b0);
    send(0, -8'sd128, 32512, "ext2", 1'b0);
    send(0, -8'sd128, 49152, "ext3", 1'b0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Multi-channel scheduler for a shared, time-multiplexed serial FIR MAC.
- Arbitrates sample requests from NCH independent channels using round-robin.
- Keeps a per-channel NTAP-deep sample delay line and one shared coefficient bank.
- Sequences the external MAC one tap per cycle, then returns the tagged result to the output.

Parameters:
- NCH, 2, number of input channels (2..8)
- NTAP, 3, filter taps per channel
- DW, 8, signed sample width
- CW, 8, signed coefficient width
- AW, 18, accumulator/result width (must be >= DW+CW+clog2(NTAP))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  NCH  per-channel sample request
- in_data  in  NCH*DW  channel c sample at bits [c*DW +: DW], signed
- in_ready  out  NCH  one-hot grant; at most one bit set
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAP)  tap index to write
- coef_data  in  CW  signed coefficient
- coef_ready  out  1  high only in IDLE; a write is accepted when coef_we & coef_ready
- mac_a  out  DW  sample operand to the MAC
- mac_b  out  CW  coefficient operand to the MAC
- mac_en  out  1  MAC update strobe
- mac_clr  out  1  with mac_en: acc <= a*b; otherwise acc <= acc + a*b
- mac_acc  in  AW  registered MAC accumulator, signed
- out_valid  out  1  one-cycle result strobe
- out_chan  out  clog2(NCH)  channel of the result
- out_data  out  AW  signed filter result
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, RUN, OUT.
- Reset values:
  - state = IDLE; all delay lines = 0; all coefficients = 0; rr pointer = NCH-1, so channel 0 has first priority.
  - in_ready = 0, out_valid = 0, out_chan = 0, out_data = 0, mac_en = 0, mac_clr = 0, mac_a = 0, mac_b = 0.
- IDLE:
  - coef_ready = 1.
  - If coef_we is high: write h[coef_addr] <= coef_data. If coef_addr >= NTAP, the write is dropped. No grant is issued in that cycle; coefficient writes win over samples.
  - Otherwise, the lowest-index requesting channel at or after rr+1 (wrapping modulo NCH) gets in_ready combinationally in the same cycle.
  - On the handshake edge: shift that channel's delay line (x[c][0] <= in_data_c, x[c][k] <= x[c][k-1]); ch <= c; rr <= c; tap <= 0; go to RUN.
  - With no requests, stay in IDLE.
- RUN, one cycle per tap k = 0..NTAP-1:
  - mac_a = x[ch][k], mac_b = h[k], mac_en = 1, mac_clr = (k == 0).
  - After the edge where k = NTAP-1, go to OUT.
  - in_ready = 0 and coef_ready = 0 throughout.
- MAC contract: the external MAC register updates on the same edge that mac_en is sampled. mac_acc is therefore valid in OUT.
- OUT:
  - out_valid = 1, out_data = mac_acc, out_chan = ch, held for exactly one cycle.
  - Next state is IDLE.
- Latency and throughput:
  - If the handshake happens in cycle n, out_valid is high in cycle n+NTAP+1.
  - The next grant can happen no earlier than cycle n+NTAP+2.
  - Throughput is 1 sample per NTAP+2 cycles, aggregated across all channels.
- Arithmetic: all values are two's complement. No saturation is applied; AW guarantees no overflow.
- Channel isolation: a channel's delay line shifts only on its own handshake.
- in_valid deasserted without a grant: the request is simply dropped, with no side effects.
- A channel holding in_valid high while not granted keeps its data; the source must hold it stable.
- rst asserted in any state, including mid-RUN: the next cycle is IDLE with all reset values, and any in-flight result is discarded (no out_valid).
- mac_en is never high outside RUN.

Test Plan:
- Reset, then coefficient load: rst for 2 cycles, then write h = {5, -5, 15} in IDLE → coef_ready = 1 during the writes and each write lands. Probe readback via one sample: ch0 sample 1 → out_data = 5, out_chan = 0.
- Single-channel sequence: ch0 samples 1, 2, 3 → out_data = 5, 5, 20. out_valid occurs exactly 4 cycles after each handshake, and each handshake is spaced at least 5 cycles from the previous one.
- Round-robin fairness: ch0 and ch1 both continuously valid → grants alternate 0, 1, 0, 1. Each channel's result is computed from its own history: ch1 samples -2, 4 → -10, 30.
- Coefficient write while busy: coef_we with addr 0, data 7 during RUN → ignored (coef_ready = 0); the current and next results still use h[0] = 5. The same write in IDLE → the next result uses 7, and no grant is issued in that cycle.
- Reset mid-operation: rst asserted during tap 1 → no out_valid; state returns to IDLE, busy = 0, coefficients and delay lines read back as 0 (ch0 sample 9 → out_data = 0).
- Boundaries: coef_addr = 3 with NTAP = 3 → write dropped. Extreme values: all samples -128 and all h = -128 → out_data = 49152, with no overflow at AW = 18.
